// File: rtl/abro_input_conditioner_if.sv
// Signal bundle between the raw button inputs and the ABRO-facing debounced outputs.
// The conditioner uses the slave modport; the block feeding it raw levels uses master.
interface abro_input_conditioner_if;
    logic a_raw;
    logic b_raw;
    logic A;
    logic B;
    logic a_chg;
    logic b_chg;
    logic busy;

    modport master (
        output a_raw, b_raw,
        input  A, B, a_chg, b_chg, busy
    );

    modport slave (
        input  a_raw, b_raw,
        output A, B, a_chg, b_chg, busy
    );
endinterface

// File: rtl/abro_input_conditioner.sv
// Two-channel synchronizer + debouncer producing the ABRO A/B inputs with change strobes.
// Define ABRO_COND_SYNC_EN to insert the 2-flop synchronizer; leave it undefined for synchronous sources.
module abro_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic                      clk,
    input logic                      rst,
    abro_input_conditioner_if.slave  bus
);
    localparam logic [1:0] IDLE_LOW     = 2'd0;
    localparam logic [1:0] CONFIRM_HIGH = 2'd1;
    localparam logic [1:0] HIGH         = 2'd2;
    localparam logic [1:0] CONFIRM_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] s;
    logic [1:0] level;
    logic [1:0] chg;
    logic [1:0] confirming;

    assign raw = {bus.b_raw, bus.a_raw};

`ifdef ABRO_COND_SYNC_EN
    logic [1:0] sync1;
    logic [1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = raw;
`endif

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             out;
        logic             strobe;

        // cnt counts consecutive opposite samples; any agreeing sample drops back to the stable state
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE_LOW;
                cnt    <= '0;
                out    <= 1'b0;
                strobe <= 1'b0;
            end else begin
                strobe <= 1'b0;
                case (state)
                    IDLE_LOW: begin
                        if (s[ch]) begin
                            state <= CONFIRM_HIGH;
                            cnt   <= CNT_ONE;
                        end
                    end
                    CONFIRM_HIGH: begin
                        if (!s[ch]) begin
                            state <= IDLE_LOW;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= HIGH;
                            cnt    <= '0;
                            out    <= 1'b1;
                            strobe <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (!s[ch]) begin
                            state <= CONFIRM_LOW;
                            cnt   <= CNT_ONE;
                        end
                    end
                    CONFIRM_LOW: begin
                        if (s[ch]) begin
                            state <= HIGH;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= IDLE_LOW;
                            cnt    <= '0;
                            out    <= 1'b0;
                            strobe <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end

        assign level[ch]      = out;
        assign chg[ch]        = strobe;
        assign confirming[ch] = (state == CONFIRM_HIGH) || (state == CONFIRM_LOW);
    end

    assign bus.A     = level[0];
    assign bus.B     = level[1];
    assign bus.a_chg = chg[0];
    assign bus.b_chg = chg[1];
    assign bus.busy  = |confirming;
endmodule

// File: tb/tb_abro_input_conditioner.sv
// Self-checking bench for abro_input_conditioner: directed latency/abort scenarios plus
// randomized bouncing inputs compared each cycle against a run-length reference model.
module tb_abro_input_conditioner;
    localparam int D = 4;
`ifdef ABRO_COND_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    // Counting edge 1 as the first edge after raw settles: edge at which the output flips,
    // and first edge at which the FSM has seen the new level.
    localparam int CHG_EDGE   = SYNC ? D + 2 : D;
    localparam int BUSY_START = SYNC ? 3 : 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    abro_input_conditioner_if bus();

    abro_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the output flips once D consecutive samples disagree with it.
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] m_out;
    logic [1:0] m_chg;
    int         run [2];
    logic [1:0] raw_now;
    logic [1:0] smp;

    assign raw_now = {bus.b_raw, bus.a_raw};
    assign smp     = SYNC ? p1 : raw_now;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p0     <= '0;
            p1     <= '0;
            m_out  <= '0;
            m_chg  <= '0;
            run[0] <= 0;
            run[1] <= 0;
        end else begin
            p0 <= raw_now;
            p1 <= p0;
            for (int c = 0; c < 2; c++) begin
                if (smp[c] != m_out[c]) begin
                    if (run[c] == D - 1) begin
                        m_out[c] <= ~m_out[c];
                        m_chg[c] <= 1'b1;
                        run[c]   <= 0;
                    end else begin
                        run[c]   <= run[c] + 1;
                        m_chg[c] <= 1'b0;
                    end
                end else begin
                    run[c]   <= 0;
                    m_chg[c] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [4:0] model_vec();
        return {m_out[0], m_out[1], m_chg[0], m_chg[1], (run[0] != 0) || (run[1] != 0)};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.A, bus.B, bus.a_chg, bus.b_chg, bus.busy};
    endfunction

    task automatic applyStimulus(input logic a, input logic b);
        bus.a_raw = a;
        bus.b_raw = b;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (dut_vec() !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_values got=%b exp=%b", dut_vec(), 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== 5'b0 || model_vec() !== 5'b0) begin
                failures++;
                $display("[TB] FAIL idle_after_reset cycle=%0d got=%b exp=%b", e, dut_vec(), 5'b0);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [2:0] exp;
        pulse_reset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= CHG_EDGE + 2; e++) begin
            @(negedge clk);
            exp = {e >= CHG_EDGE, e == CHG_EDGE, (e >= BUSY_START) && (e < CHG_EDGE)};
            checks++;
            if ({bus.A, bus.a_chg, bus.busy} !== exp || dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL rise_latency edge=%0d got A/chg/busy=%b exp=%b full got=%b model=%b",
                         e, {bus.A, bus.a_chg, bus.busy}, exp, dut_vec(), model_vec());
            end
        end
        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= CHG_EDGE + 1; e++) begin
            @(negedge clk);
            exp = {e < CHG_EDGE, e == CHG_EDGE, (e >= BUSY_START) && (e < CHG_EDGE)};
            checks++;
            if ({bus.A, bus.a_chg, bus.busy} !== exp || dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL fall_latency edge=%0d got A/chg/busy=%b exp=%b",
                         e, {bus.A, bus.a_chg, bus.busy}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        pulse_reset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
            checks++;
            if (bus.A !== 1'b0 || bus.a_chg !== 1'b0 || dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL glitch_rejected edge=%0d got A=%b a_chg=%b exp 0/0", e, bus.A, bus.a_chg);
            end
            if (e == D - 1) applyStimulus(1'b0, 1'b0);
        end
        checks++;
        if (saw_busy !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_busy got saw_busy=%b busy_end=%b exp 1/0", saw_busy, bus.busy);
        end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        applyStimulus(1'b1, 1'b1);
        for (int e = 1; e <= CHG_EDGE + 4; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL simul_rise_model edge=%0d got=%b exp=%b", e, dut_vec(), model_vec());
            end
            if (e == CHG_EDGE) begin
                checks++;
                if ({bus.A, bus.B, bus.a_chg, bus.b_chg} !== 4'b1111) begin
                    failures++;
                    $display("[TB] FAIL simul_rise got=%b exp=%b", {bus.A, bus.B, bus.a_chg, bus.b_chg}, 4'b1111);
                end
            end
        end
        applyStimulus(1'b0, 1'b0);
        for (int e = 1; e <= CHG_EDGE + 1; e++) begin
            @(negedge clk);
            if (e == CHG_EDGE - 1 || e == CHG_EDGE) begin
                checks++;
                if ({bus.A, bus.B, bus.a_chg, bus.b_chg} !== ((e == CHG_EDGE) ? 4'b0011 : 4'b1100)) begin
                    failures++;
                    $display("[TB] FAIL simul_fall edge=%0d got=%b exp=%b", e,
                             {bus.A, bus.B, bus.a_chg, bus.b_chg}, (e == CHG_EDGE) ? 4'b0011 : 4'b1100);
                end
            end
        end
    endtask

    task automatic test_reset_mid_confirm();
        logic [1:0] exp;
        pulse_reset();
        applyStimulus(1'b1, 1'b0);
        for (int e = 1; e <= BUSY_START + 1; e++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.A !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_confirm_busy got busy=%b A=%b exp 1/0", bus.busy, bus.A);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.A, bus.a_chg, bus.busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL async_reset got A/chg/busy=%b exp=000", {bus.A, bus.a_chg, bus.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= CHG_EDGE + 1; e++) begin
            @(negedge clk);
            exp = {e >= CHG_EDGE, e == CHG_EDGE};
            checks++;
            if ({bus.A, bus.a_chg} !== exp || dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL confirm_after_reset edge=%0d got A/chg=%b exp=%b", e, {bus.A, bus.a_chg}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] cur;
        int         last_strobe [2];
        int         strobes;
        bit         noisy;
        strobes        = 0;
        last_strobe[0] = -1000;
        last_strobe[1] = -1000;
        cur            = 2'b00;
        noisy          = 1'b1;
        pulse_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL random_model cycle=%0d got=%b exp=%b", cyc, dut_vec(), model_vec());
            end
            for (int c = 0; c < 2; c++) begin
                if ((c == 0 ? bus.a_chg : bus.b_chg) === 1'b1) begin
                    strobes++;
                    checks++;
                    if (cyc - last_strobe[c] < D) begin
                        failures++;
                        $display("[TB] FAIL strobe_spacing ch=%0d got=%0d exp>=%0d", c, cyc - last_strobe[c], D);
                    end
                    last_strobe[c] = cyc;
                end
            end
            if (cyc % 50 == 0) noisy = ~noisy;
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 19) < (noisy ? 6 : 1)) cur[c] = ~cur[c];
            end
            applyStimulus(cur[0], cur[1]);
        end
        checks++;
        if (strobes == 0) begin
            failures++;
            $display("[TB] FAIL random_activity got strobes=%0d exp>0", strobes);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0);
        $display("[TB] start SYNC=%0d DEBOUNCE_CYCLES=%0d", SYNC, D);
        test_reset();
        test_single_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid_confirm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/abro_input_conditioner.md
# abro_input_conditioner

Two-channel input conditioner that sits directly upstream of the ABRO state machine and produces its `A` and `B` inputs. It takes raw, asynchronous, bouncy button levels, synchronizes them, and debounces each channel independently. It presents clean level outputs plus one-cycle change strobes and a settling flag. Both channels share one timing path, so raw edges that arrive together reach the ABRO stage on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a new level; legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `a_raw` in 1: raw level for channel A; asynchronous to `clk`.
- `b_raw` in 1: raw level for channel B; asynchronous to `clk`.
- `A` out 1: debounced level for channel A; feeds the ABRO `A` input; registered.
- `B` out 1: debounced level for channel B; feeds the ABRO `B` input; registered.
- `a_chg` out 1: one-cycle strobe, asserted in the same cycle `A` takes a new value.
- `b_chg` out 1: one-cycle strobe, asserted in the same cycle `B` takes a new value.
- `busy` out 1: high while either channel is in a CONFIRM state.

## Operation
- Per channel, a 2-flop synchronizer produces `s`. With the sync feature out, `s` is the raw input directly.
- Per-channel FSM states: `IDLE_LOW` (out=0), `CONFIRM_HIGH`, `HIGH` (out=1), `CONFIRM_LOW`. Count register is `cnt`.
- `IDLE_LOW`: if `s`=1, go to `CONFIRM_HIGH` with `cnt`=1; otherwise stay.
- `CONFIRM_HIGH`, when `s`=0: return to `IDLE_LOW` with `cnt`=0, no strobe.
- `CONFIRM_HIGH`, when `s`=1 and `cnt`==`DEBOUNCE_CYCLES-1`: go to `HIGH`, set out=1, pulse chg.
- `CONFIRM_HIGH`, otherwise: increment `cnt`.
- `HIGH` and `CONFIRM_LOW` mirror the above with polarity inverted. Exit to `IDLE_LOW` sets out=0 and pulses chg.
- Net effect: the output changes on the `DEBOUNCE_CYCLES`-th consecutive sample of the opposite level.
- Any single opposite sample during CONFIRM aborts the confirm and restarts the count from zero on the next change.
- Channels are fully independent; no arbitration. Simultaneous confirms on A and B complete on the same edge.
- `busy` = OR over both channels of (state is CONFIRM_*). It is registered-state derived, with no combinational path from raw inputs.
- `cnt` never wraps: it is bounded by `DEBOUNCE_CYCLES-1` and cleared on every exit from CONFIRM.

## Timing
- Reset values: `A`=0, `B`=0, `a_chg`=0, `b_chg`=0, `busy`=0. Both FSMs in `IDLE_LOW`, `cnt`=0, synchronizer flops 0.
- `rst` clears all state immediately, independent of `clk`.
- Reset mid-CONFIRM: the confirm is abandoned and no strobe is ever emitted for it.
- After `rst` deassertion, the first FSM evaluation happens on the next rising edge.
- Sync feature in: raw held stable from before edge k means the output and strobe change at edge k+`DEBOUNCE_CYCLES`+1. For the default, that is k+5.
- Sync feature out: the output and strobe change at edge k+`DEBOUNCE_CYCLES`-1.
- A strobe lasts exactly one cycle. The output level holds until a full opposite confirm completes.
- Minimum spacing between consecutive strobes on one channel is `DEBOUNCE_CYCLES` cycles.

## Configuration
- `ABRO_COND_SYNC_EN` defined: the 2-flop synchronizer is present on each channel. This is the required setting for board-level, truly asynchronous buttons.
- `ABRO_COND_SYNC_EN` undefined: the synchronizer is removed and `s` equals the raw input. Latency drops by 2 cycles. Intended only for testbenches and already-synchronous sources.
- Nothing else changes with the macro: FSM, ports, and reset behaviour are identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ABRO_COND_SYNC_EN` defined unless stated.
- Release `rst` with `a_raw`=`b_raw`=0, run 20 cycles -> `A`=`B`=0; no `a_chg`/`b_chg`; `busy`=0 throughout.
- `a_raw` 0->1 before edge 10, held -> `busy`=1 after edges 12–14; `A`=1 with `a_chg`=1 after edge 15 only; `busy`=0 after edge 15.
- `a_raw` high for exactly 3 cycles then low -> `A` stays 0; no `a_chg`; `busy` rises then returns to 0.
- `a_raw` and `b_raw` rise before the same edge 10 -> `A`, `B`, `a_chg` and `b_chg` all assert after edge 15 together. Then both fall before edge 30 -> both clear after edge 35.
- `a_raw` 0->1 before edge 10; `rst` pulsed between edges 13 and 14; `a_raw` kept at 1 -> `A`=0 and `busy`=0 during reset; no `a_chg` for the aborted confirm; a fresh confirm then completes per the latency rule.
- `ABRO_COND_SYNC_EN` undefined, `b_raw` 0->1 before edge 10 -> `B`=1 with `b_chg`=1 after edge 13.
